// File: rtl/onewire_pkg.sv
// Shared state type, ROM/function command codes and timing helper
// for the 1-Wire slave emulator.
package onewire_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_LOW,
    PRES_WAIT,
    PRES_DRIVE,
    ROM_CMD,
    FUNC_CMD,
    TX_SP,
    CONV_POLL,
    HALT
  } ow_state_t;

  localparam logic [7:0] ROM_SKIP   = 8'hCC;
  localparam logic [7:0] FN_CONVERT = 8'h44;
  localparam logic [7:0] FN_READ_SP = 8'hBE;

  // Timers start from zero, so an interval of `us` ends on the tick seen while the count is us-1.
  function automatic logic [15:0] us_to_ticks(input int unsigned us);
    return (us == 0) ? 16'd0 : 16'(us - 1);
  endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// One-cycle tick every DIV clocks; restart realigns the phase so the next
// tick lands exactly DIV cycles later.
module onewire_us_tick #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/onewire_slave_emu.sv
// DS18B20-style 1-Wire slave: reset/presence, SKIP ROM, CONVERT T polling
// and READ SCRATCHPAD from a user-supplied scratchpad.
module onewire_slave_emu
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int RESET_MIN_US      = 480,
  parameter int PRESENCE_DELAY_US = 30,
  parameter int PRESENCE_LEN_US   = 120,
  parameter int SAMPLE_US         = 30,
  parameter int READ_HOLD_US      = 30,
  parameter int SP_BYTES          = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dq_i,
  output logic                    dq_oe_o,
  input  logic [8*SP_BYTES-1:0]   scratchpad_i,
  input  logic                    conv_busy_i,
  output logic                    convert_o,
  output logic [7:0]              cmd_o,
  output logic                    cmd_valid_o,
  output logic                    bus_reset_o
);

  localparam int          DIV          = CLK_FREQ_HZ / 1_000_000;
  localparam int          SPW          = 8 * SP_BYTES;
  localparam logic [15:0] T_PRES_DELAY = us_to_ticks(PRESENCE_DELAY_US);
  localparam logic [15:0] T_PRES_LEN   = us_to_ticks(PRESENCE_LEN_US);
  localparam logic [15:0] T_SAMPLE     = us_to_ticks(SAMPLE_US);
  localparam logic [15:0] T_HOLD       = us_to_ticks(READ_HOLD_US);
  localparam logic [15:0] RST_LEN      = 16'(RESET_MIN_US);

  ow_state_t        state, state_next;
  logic             dq_meta, dq_sync, dq_prev;
  logic             fall, rise, fall_ok;
  logic             tick, tick_restart, tmr_done;
  logic             rst_det, wr_sample, byte_done, rd_bit;
  logic             drive, slot_active;
  logic [15:0]      tmr, tmr_target, low_us;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_byte, rx_next;
  logic [SPW-1:0]   tx_sr;

  // Idle bus is high, so the synchroniser resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_meta <= 1'b1;
      dq_sync <= 1'b1;
      dq_prev <= 1'b1;
    end else begin
      dq_meta <= dq_i;
      dq_sync <= dq_meta;
      dq_prev <= dq_sync;
    end
  end

  assign fall    = dq_prev && !dq_sync;
  assign rise    = !dq_prev && dq_sync;
  assign fall_ok = fall && !drive;

  assign tick_restart = fall_ok || (state == RST_LOW && rise);

  onewire_us_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tick_restart),
    .tick    (tick)
  );

  assign rst_det   = tick && !dq_sync && (low_us == RST_LEN - 16'd1);
  assign tmr_done  = tick && (tmr == tmr_target);
  assign wr_sample = slot_active && tmr_done && (state == ROM_CMD || state == FUNC_CMD);
  assign rx_next   = {dq_sync, rx_byte[7:1]};
  assign byte_done = wr_sample && (bit_cnt == 3'd7);
  assign rd_bit    = (state == TX_SP) ? tx_sr[0] : !conv_busy_i;
  assign dq_oe_o   = drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tmr_target = 16'hFFFF;
    case (state)
      PRES_WAIT:          tmr_target = T_PRES_DELAY;
      PRES_DRIVE:         tmr_target = T_PRES_LEN;
      ROM_CMD, FUNC_CMD:  tmr_target = T_SAMPLE;
      TX_SP, CONV_POLL:   tmr_target = T_HOLD;
      default:            ;
    endcase
    case (state)
      RST_LOW:    if (rise) state_next = PRES_WAIT;
      PRES_WAIT:  if (tmr_done) state_next = PRES_DRIVE;
      PRES_DRIVE: if (tmr_done) state_next = ROM_CMD;
      ROM_CMD:    if (byte_done) state_next = (rx_next == ROM_SKIP) ? FUNC_CMD : HALT;
      FUNC_CMD: begin
        if (byte_done) begin
          case (rx_next)
            FN_CONVERT: state_next = CONV_POLL;
            FN_READ_SP: state_next = TX_SP;
            default:    state_next = HALT;
          endcase
        end
      end
      default: ;
    endcase
    if (rst_det) state_next = RST_LOW;
  end

  // Datapath: line-low timer, slot timer, bit shifters and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_us      <= '0;
      tmr         <= '0;
      drive       <= 1'b0;
      slot_active <= 1'b0;
      bit_cnt     <= '0;
      rx_byte     <= '0;
      tx_sr       <= '0;
      cmd_o       <= 8'h00;
      cmd_valid_o <= 1'b0;
      convert_o   <= 1'b0;
      bus_reset_o <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      convert_o   <= 1'b0;
      bus_reset_o <= 1'b0;

      if (dq_sync)                        low_us <= '0;
      else if (tick && low_us != RST_LEN) low_us <= low_us + 16'd1;

      if (tick_restart || state_next != state) tmr <= '0;
      else if (tick)                           tmr <= tmr + 16'd1;

      if (rst_det) begin
        bus_reset_o <= 1'b1;
        drive       <= 1'b0;
        slot_active <= 1'b0;
        bit_cnt     <= '0;
      end else begin
        case (state)
          PRES_WAIT:  if (tmr_done) drive <= 1'b1;
          PRES_DRIVE: if (tmr_done) drive <= 1'b0;
          ROM_CMD, FUNC_CMD: begin
            if (fall_ok) begin
              slot_active <= 1'b1;
            end else if (wr_sample) begin
              slot_active <= 1'b0;
              rx_byte     <= rx_next;
              bit_cnt     <= bit_cnt + 3'd1;
              if (byte_done) begin
                cmd_o       <= rx_next;
                cmd_valid_o <= 1'b1;
                if (state == FUNC_CMD && rx_next == FN_CONVERT) convert_o <= 1'b1;
                if (state == FUNC_CMD && rx_next == FN_READ_SP) tx_sr <= scratchpad_i;
              end
            end
          end
          // Shifting in ones makes every slot past the scratchpad read as 1.
          TX_SP, CONV_POLL: begin
            if (fall_ok) begin
              drive <= !rd_bit;
              if (state == TX_SP) tx_sr <= {1'b1, tx_sr[SPW-1:1]};
            end else if (drive && tmr_done) begin
              drive <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onewire_slave_emu.sv
// Self-checking bench: a bus-master model drives reset, write and read slots
// on an open-drain line and checks timing and data against a simple model.
module tb_onewire_slave_emu;
  import onewire_pkg::*;

  localparam int CLK_HZ = 2_000_000;
  localparam int US     = CLK_HZ / 1_000_000;
  localparam int SPB    = 9;

  typedef struct { int low_us; bit exp_reset; bit exp_presence; } pulse_vec_t;
  typedef struct { bit busy; bit exp_bit; } poll_vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 master_low = 1'b0;
  logic                 conv_busy = 1'b0;
  logic [8*SPB-1:0]     scratchpad = '0;
  logic                 dq, dq_oe, convert, cmd_valid, bus_reset;
  logic [7:0]           cmd;

  int checks = 0, passes = 0;
  int cyc = 0, n_reset = 0, reset_cyc = 0, n_convert = 0, conv_unaligned = 0;
  int oe_at_reset_bad = 0, oe_rise_cyc = -1, oe_fall_cyc = -1, max_lat = 0;
  logic oe_prev = 1'b0;
  logic [7:0] cmd_log[$];
  logic [7:0] sp_model[SPB];

  assign dq = ~(master_low | dq_oe);

  onewire_slave_emu #(.CLK_FREQ_HZ(CLK_HZ), .SP_BYTES(SPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dq_i         (dq),
    .dq_oe_o      (dq_oe),
    .scratchpad_i (scratchpad),
    .conv_busy_i  (conv_busy),
    .convert_o    (convert),
    .cmd_o        (cmd),
    .cmd_valid_o  (cmd_valid),
    .bus_reset_o  (bus_reset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_reset) begin
      n_reset++;
      reset_cyc = cyc;
      if (dq_oe) oe_at_reset_bad++;
    end
    if (cmd_valid) cmd_log.push_back(cmd);
    if (convert) begin
      n_convert++;
      if (!cmd_valid || cmd != FN_CONVERT) conv_unaligned++;
    end
    if (dq_oe && !oe_prev) oe_rise_cyc = cyc;
    if (!dq_oe && oe_prev) oe_fall_cyc = cyc;
    oe_prev = dq_oe;
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  task automatic waitUs(input int n);
    repeat (n * US) @(negedge clk);
  endtask

  task automatic writeBit(input bit b);
    master_low = 1'b1;
    waitUs(b ? 1 : 60);
    master_low = 1'b0;
    waitUs(b ? 64 : 5);
  endtask

  task automatic writeByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) writeBit(v[i]);
  endtask

  task automatic readBit(output bit val, output bit drove);
    int lat;
    lat = -1; drove = 1'b0; val = 1'b1;
    master_low = 1'b1;
    for (int i = 1; i <= 45 * US; i++) begin
      @(negedge clk);
      if (i == US) master_low = 1'b0;
      if (dq_oe && lat < 0) lat = i;
      if (dq_oe) drove = 1'b1;
      if (i == 15 * US) val = dq;
    end
    if (lat > max_lat) max_lat = lat;
  endtask

  // Low pulse of low_us, then 200 us of observation for the presence answer.
  task automatic applyStimulus(input int low_us, output int rst_cnt, output int rst_delay,
                               output int pres_delay, output int pres_len);
    int r0, rise0, fall_c, rel_c;
    r0 = n_reset; rise0 = oe_rise_cyc;
    fall_c = cyc;
    master_low = 1'b1;
    waitUs(low_us);
    master_low = 1'b0;
    rel_c = cyc;
    waitUs(200);
    rst_cnt    = n_reset - r0;
    rst_delay  = reset_cyc - fall_c;
    pres_delay = (oe_rise_cyc != rise0) ? oe_rise_cyc - rel_c : -1;
    pres_len   = oe_fall_cyc - oe_rise_cyc;
  endtask

  task automatic doReset(input string tag);
    int rc, rd, pd, pl;
    applyStimulus(500, rc, rd, pd, pl);
    checkOutput({tag, " reset count"}, rc, 1);
    checkRange({tag, " presence delay"}, pd, 30 * US, 31 * US + 4);
  endtask

  function automatic bit modelReadBit(input logic [7:0] bytes[SPB], input int slot);
    if (slot >= 8 * SPB) return 1'b1;
    return bytes[slot / 8][slot % 8];
  endfunction

  task automatic randomizeScratchpad();
    for (int k = 0; k < SPB; k++) scratchpad[8*k +: 8] = 8'($urandom);
  endtask

  task automatic captureModel();
    for (int k = 0; k < SPB; k++) sp_model[k] = scratchpad[8*k +: 8];
  endtask

  initial begin
    pulse_vec_t pulse_tab[4];
    poll_vec_t  poll_tab[5];
    int rc, rd, pd, pl, n0, c0;
    bit v, d, any_drive;

    pulse_tab[0] = '{500, 1'b1, 1'b1};
    pulse_tab[1] = '{470, 1'b0, 1'b0};
    pulse_tab[2] = '{300, 1'b0, 1'b0};
    pulse_tab[3] = '{490, 1'b1, 1'b1};
    poll_tab[0]  = '{1'b1, 1'b0};
    poll_tab[1]  = '{1'b1, 1'b0};
    poll_tab[2]  = '{1'b0, 1'b1};
    poll_tab[3]  = '{1'b1, 1'b0};
    poll_tab[4]  = '{1'b0, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset dq_oe", dq_oe, 0);
    checkOutput("reset cmd", cmd, 0);
    checkOutput("reset cmd_valid", cmd_valid, 0);
    checkOutput("reset bus_reset", bus_reset, 0);
    checkOutput("reset convert", convert, 0);
    rst_n = 1'b1;
    waitUs(10);

    $display("[TB] reset/presence pulse table");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pulse_tab[i].low_us, rc, rd, pd, pl);
      checkOutput($sformatf("pulse%0d reset count", i), rc, int'(pulse_tab[i].exp_reset));
      if (pulse_tab[i].exp_reset)
        checkRange($sformatf("pulse%0d reset delay", i), rd, 480 * US, 481 * US + 4);
      if (pulse_tab[i].exp_presence) begin
        checkRange($sformatf("pulse%0d presence delay", i), pd, 30 * US, 31 * US + 4);
        checkRange($sformatf("pulse%0d presence length", i), pl, 119 * US, 121 * US);
      end else begin
        checkOutput($sformatf("pulse%0d no presence", i), pd, -1);
      end
    end

    $display("[TB] convert and poll");
    doReset("conv");
    n0 = cmd_log.size(); c0 = n_convert;
    writeByte(ROM_SKIP);
    writeByte(FN_CONVERT);
    checkOutput("conv cmd count", cmd_log.size() - n0, 2);
    if (cmd_log.size() >= n0 + 2) begin
      checkOutput("conv cmd 0", cmd_log[n0], ROM_SKIP);
      checkOutput("conv cmd 1", cmd_log[n0+1], FN_CONVERT);
    end
    checkOutput("convert pulses", n_convert - c0, 1);
    checkOutput("convert aligned with cmd_valid", conv_unaligned, 0);
    for (int i = 0; i < 5; i++) begin
      conv_busy = poll_tab[i].busy;
      readBit(v, d);
      checkOutput($sformatf("poll%0d bit", i), v, poll_tab[i].exp_bit);
    end
    for (int i = 0; i < 8; i++) begin
      conv_busy = 1'($urandom_range(0, 1));
      readBit(v, d);
      checkOutput($sformatf("poll rand%0d bit", i), v, !conv_busy);
    end
    conv_busy = 1'b0;

    $display("[TB] scratchpad read");
    randomizeScratchpad();
    scratchpad[7:0]  = 8'h50;
    scratchpad[15:8] = 8'h05;
    captureModel();
    doReset("sp");
    writeByte(ROM_SKIP);
    writeByte(FN_READ_SP);
    checkOutput("sp last cmd", cmd_log[$], FN_READ_SP);
    randomizeScratchpad();
    for (int s = 0; s < 8 * SPB + 4; s++) begin
      readBit(v, d);
      checkOutput($sformatf("sp slot%0d", s), v, modelReadBit(sp_model, s));
    end
    checkRange("read drive latency", max_lat, 1, 4);

    $display("[TB] unknown command");
    doReset("unk");
    writeByte(8'h55);
    checkOutput("unk last cmd", cmd_log[$], 8'h55);
    n0 = cmd_log.size();
    any_drive = 1'b0;
    for (int i = 0; i < 8; i++) begin
      readBit(v, d);
      any_drive |= d;
    end
    checkOutput("halt never drives", any_drive, 0);
    checkOutput("halt no new cmd", cmd_log.size() - n0, 0);
    doReset("after halt");

    $display("[TB] abort during scratchpad read");
    randomizeScratchpad();
    captureModel();
    doReset("abort");
    writeByte(ROM_SKIP);
    writeByte(FN_READ_SP);
    for (int s = 0; s < 19; s++) begin
      readBit(v, d);
      checkOutput($sformatf("abort pre slot%0d", s), v, modelReadBit(sp_model, s));
    end
    randomizeScratchpad();
    captureModel();
    doReset("abort mid-byte");
    checkOutput("oe released at reset", oe_at_reset_bad, 0);
    writeByte(ROM_SKIP);
    writeByte(FN_READ_SP);
    for (int s = 0; s < 8; s++) begin
      readBit(v, d);
      checkOutput($sformatf("abort restart slot%0d", s), v, modelReadBit(sp_model, s));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
